multicycle_control: RTL
=======================

# multicycle_control

Multicycle control FSM for the computer's datapath. Sequences fetch, decode, execute, memory and writeback for each instruction, and drives the enables for the instruction register, PC, A/B operand registers, ALU, memory and register file. Handles variable-latency memory through a ready handshake and counts retired instructions. Sits beside the datapath top level, taking the opcode from the instruction register and status flags from the ALU and memory.

## Interface
- OPCODE_W, default 4: opcode width (matches `WIDTH_OPCODE).
- COUNT_W, default 16: retired-instruction counter width.

- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; low forces IDLE.
- start  in  1  one-cycle pulse; begins execution from IDLE.
- opcode  in  OPCODE_W  from the instruction register; valid from DECODE onward.
- alu_zero  in  1  ALU result == 0.
- mem_ready  in  1  memory completes the current read or write this cycle.
- ir_enable  out  1  load the instruction register.
- pc_write  out  1  update the PC.
- pc_src  out  2  0 = PC+1, 1 = branch target, 2 = jump target.
- mem_read / mem_write  out  1 each  memory strobes, held until mem_ready.
- mem_addr_sel  out  1  0 = PC, 1 = ALU output register.
- ab_enable  out  1  latch regfile read data into the A/B registers.
- alu_op  out  2  0 = ADD, 1 = SUB, 2 = AND, 3 = OR.
- alu_src_b  out  1  0 = B register, 1 = sign-extended immediate.
- alu_out_enable  out  1  latch the ALU result.
- reg_write  out  1  register file write.
- wb_sel  out  1  0 = ALU output register, 1 = memory data register.
- halted  out  1  registered; set by HALT or an illegal opcode.
- illegal  out  1  registered; set by an undefined opcode.
- instr_count  out  COUNT_W  registered count of retired instructions.

## Operation
- Opcodes:
  - 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 ADDI, 6 LW, 7 SW, 8 BEQ, 9 JMP, 15 HALT.
  - 10–14 are illegal.
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALTED.
- IDLE: all control outputs 0. start=1 → FETCH. start is ignored in every other state.
- FETCH:
  - mem_read=1, mem_addr_sel=0.
  - While mem_ready=0, remain in FETCH.
  - On mem_ready=1, same cycle: ir_enable=1, pc_write=1, pc_src=0; → DECODE.
- DECODE: ab_enable=1, then by opcode:
  - NOP: → FETCH.
  - JMP: pc_write=1, pc_src=2; → FETCH.
  - HALT: → HALTED.
  - Illegal: set illegal; → HALTED.
  - All others: → EXECUTE.
- EXECUTE: alu_out_enable=1, then by opcode:
  - R-type (ADD/SUB/AND/OR): alu_src_b=0, alu_op per opcode; → WRITEBACK.
  - ADDI: ADD, alu_src_b=1; → WRITEBACK.
  - LW/SW: ADD, alu_src_b=1; → MEM.
  - BEQ: SUB, alu_src_b=0; pc_write=alu_zero, pc_src=1; → FETCH.
- MEM:
  - mem_addr_sel=1; LW asserts mem_read, SW asserts mem_write.
  - Hold until mem_ready. Then LW → WRITEBACK, SW → FETCH.
- WRITEBACK: reg_write=1; wb_sel=1 for LW, else 0; → FETCH.
- HALTED: halted=1; all strobes 0. Only reset exits this state.
- Output decode:
  - All control outputs are combinational from state, opcode, alu_zero and mem_ready.
  - state, halted, illegal and instr_count are registered.
- Retirement:
  - instr_count increments by 1 on the cycle an instruction leaves its final state to go to FETCH or HALTED.
  - HALT counts as retired; an illegal opcode does not.
  - The counter wraps modulo 2^COUNT_W.

## Timing
- Latency per instruction with mem_ready tied high:
  - NOP and JMP: 2 cycles.
  - BEQ: 3.
  - R-type, ADDI, SW: 4.
  - LW: 5.
  - HALT: 2, then HALTED.
- Each cycle of mem_ready=0 in FETCH or MEM adds exactly 1 cycle.
- Memory strobes stay stable while waiting; the address select does not change.
- When reset goes low, immediately (asynchronously):
  - state goes to IDLE;
  - halted, illegal and instr_count go to 0;
  - all combinational outputs go to 0.
- Reset in mid-operation abandons any pending memory access. No partial writeback occurs.
- start coincident with reset deassertion is ignored. The first start is accepted on a later clock edge.
- mem_ready while no strobe is active has no effect.

## Structure
- The shared parameters.v include holds:
  - opcode constants;
  - state encodings (3-bit);
  - alu_op and pc_src codes;
  - the illegal-opcode range.
- One natural sub-module, opcode_decode: combinational opcode → class (rtype, addi, load, store, branch, jump, nop, halt, illegal) plus alu_op.
- The FSM, counter and flags live in multicycle_control.

## Test plan
- ADD (op 1), mem_ready=1:
  - FETCH → DECODE → EXECUTE → WRITEBACK → FETCH in 4 cycles.
  - reg_write=1 only in cycle 4; instr_count 0 → 1.
- LW (op 6) with mem_ready held low for 2 cycles in FETCH and 3 in MEM:
  - 10 cycles in total.
  - mem_read and mem_addr_sel stable while waiting.
  - wb_sel=1 in WRITEBACK.
- BEQ (op 8):
  - alu_zero=1 → pc_write=1, pc_src=1 in EXECUTE.
  - alu_zero=0 → pc_write=0. Both take 3 cycles.
- Opcode 12:
  - illegal=1 and halted=1 after DECODE; instr_count unchanged.
  - start pulses ignored; reset low clears both flags.
- Assert reset low during MEM of an SW:
  - mem_write drops to 0 asynchronously; state is IDLE.
  - The next start refetches from FETCH.
- COUNT_W=4: retire 16 NOPs → instr_count wraps 15 → 0.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle control unit: opcode constants,
// FSM state encoding, ALU operation codes, PC source codes and the
// decoded instruction class.
package multicycle_control_pkg;

    localparam int unsigned OPC_W   = 4;
    localparam int unsigned STATE_W = 3;

    // Opcode map; every value not listed here (10..14) is illegal.
    localparam logic [OPC_W-1:0] OP_NOP  = 4'd0;
    localparam logic [OPC_W-1:0] OP_ADD  = 4'd1;
    localparam logic [OPC_W-1:0] OP_SUB  = 4'd2;
    localparam logic [OPC_W-1:0] OP_AND  = 4'd3;
    localparam logic [OPC_W-1:0] OP_OR   = 4'd4;
    localparam logic [OPC_W-1:0] OP_ADDI = 4'd5;
    localparam logic [OPC_W-1:0] OP_LW   = 4'd6;
    localparam logic [OPC_W-1:0] OP_SW   = 4'd7;
    localparam logic [OPC_W-1:0] OP_BEQ  = 4'd8;
    localparam logic [OPC_W-1:0] OP_JMP  = 4'd9;
    localparam logic [OPC_W-1:0] OP_HALT = 4'd15;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEM       = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_HALTED    = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_OR  = 2'd3
    } alu_op_e;

    typedef enum logic [1:0] {
        PC_SRC_INC    = 2'd0,
        PC_SRC_BRANCH = 2'd1,
        PC_SRC_JUMP   = 2'd2
    } pc_src_e;

    typedef enum logic [3:0] {
        CLS_NOP     = 4'd0,
        CLS_RTYPE   = 4'd1,
        CLS_ADDI    = 4'd2,
        CLS_LOAD    = 4'd3,
        CLS_STORE   = 4'd4,
        CLS_BRANCH  = 4'd5,
        CLS_JUMP    = 4'd6,
        CLS_HALT    = 4'd7,
        CLS_ILLEGAL = 4'd8
    } op_class_e;

    typedef struct packed {
        op_class_e op_class;
        alu_op_e   alu_op;
    } decode_t;

endpackage

// File: rtl/multicycle_control_opcode_decode.sv
// Combinational opcode classifier.
// Ports:
//   i_opcode  opcode from the instruction register
//   o_dec     instruction class plus the ALU operation for R-type opcodes
module multicycle_control_opcode_decode
    import multicycle_control_pkg::*;
#(
    parameter int unsigned OPCODE_W = 4
) (
    input  logic [OPCODE_W-1:0] i_opcode,
    output decode_t             o_dec
);

    // Anything outside the defined map, including 10..14, classifies as illegal.
    always_comb begin
        o_dec = '{op_class: CLS_ILLEGAL, alu_op: ALU_ADD};
        case (i_opcode)
            OPCODE_W'(OP_NOP):  o_dec.op_class = CLS_NOP;
            OPCODE_W'(OP_ADD):  o_dec = '{op_class: CLS_RTYPE, alu_op: ALU_ADD};
            OPCODE_W'(OP_SUB):  o_dec = '{op_class: CLS_RTYPE, alu_op: ALU_SUB};
            OPCODE_W'(OP_AND):  o_dec = '{op_class: CLS_RTYPE, alu_op: ALU_AND};
            OPCODE_W'(OP_OR):   o_dec = '{op_class: CLS_RTYPE, alu_op: ALU_OR};
            OPCODE_W'(OP_ADDI): o_dec.op_class = CLS_ADDI;
            OPCODE_W'(OP_LW):   o_dec.op_class = CLS_LOAD;
            OPCODE_W'(OP_SW):   o_dec.op_class = CLS_STORE;
            OPCODE_W'(OP_BEQ):  o_dec.op_class = CLS_BRANCH;
            OPCODE_W'(OP_JMP):  o_dec.op_class = CLS_JUMP;
            OPCODE_W'(OP_HALT): o_dec.op_class = CLS_HALT;
            default:            o_dec.op_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle datapath control FSM: sequences fetch/decode/execute/mem/
// writeback, waits on mem_ready for memory accesses, flags HALT and
// illegal opcodes and counts retired instructions.
// Ports:
//   clk, reset (async, active-low), start (pulse, accepted only in IDLE)
//   opcode, alu_zero, mem_ready                       status inputs
//   ir_enable, pc_write, pc_src, mem_read, mem_write,
//   mem_addr_sel, ab_enable, alu_op, alu_src_b,
//   alu_out_enable, reg_write, wb_sel                 combinational controls
//   halted, illegal, instr_count                      registered status
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int unsigned OPCODE_W = 4,
    parameter int unsigned COUNT_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                alu_zero,
    input  logic                mem_ready,
    output logic                ir_enable,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic                mem_read,
    output logic                mem_write,
    output logic                mem_addr_sel,
    output logic                ab_enable,
    output logic [1:0]          alu_op,
    output logic                alu_src_b,
    output logic                alu_out_enable,
    output logic                reg_write,
    output logic                wb_sel,
    output logic                halted,
    output logic                illegal,
    output logic [COUNT_W-1:0]  instr_count
);

    state_e               r_state;
    logic                 r_armed;
    logic                 r_halted;
    logic                 r_illegal;
    logic [COUNT_W-1:0]   r_count;

    state_e               w_next_state;
    logic                 w_retire;
    logic                 w_set_illegal;
    decode_t              w_dec;

    multicycle_control_opcode_decode #(
        .OPCODE_W (OPCODE_W)
    ) u_opcode_decode (
        .i_opcode (opcode),
        .o_dec    (w_dec)
    );

    // Next state and control decode; outputs follow state so reset clears them at once.
    always_comb begin
        w_next_state   = r_state;
        w_retire       = 1'b0;
        w_set_illegal  = 1'b0;
        ir_enable      = 1'b0;
        pc_write       = 1'b0;
        pc_src         = PC_SRC_INC;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_addr_sel   = 1'b0;
        ab_enable      = 1'b0;
        alu_op         = ALU_ADD;
        alu_src_b      = 1'b0;
        alu_out_enable = 1'b0;
        reg_write      = 1'b0;
        wb_sel         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // r_armed blocks a start seen on the first edge after reset release.
                if (start && r_armed) begin
                    w_next_state = ST_FETCH;
                end
            end

            ST_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_enable    = 1'b1;
                    pc_write     = 1'b1;
                    pc_src       = PC_SRC_INC;
                    w_next_state = ST_DECODE;
                end
            end

            ST_DECODE: begin
                ab_enable = 1'b1;
                case (w_dec.op_class)
                    CLS_NOP: begin
                        w_next_state = ST_FETCH;
                        w_retire     = 1'b1;
                    end
                    CLS_JUMP: begin
                        pc_write     = 1'b1;
                        pc_src       = PC_SRC_JUMP;
                        w_next_state = ST_FETCH;
                        w_retire     = 1'b1;
                    end
                    CLS_HALT: begin
                        w_next_state = ST_HALTED;
                        w_retire     = 1'b1;
                    end
                    CLS_ILLEGAL: begin
                        w_set_illegal = 1'b1;
                        w_next_state  = ST_HALTED;
                    end
                    default: w_next_state = ST_EXECUTE;
                endcase
            end

            ST_EXECUTE: begin
                alu_out_enable = 1'b1;
                case (w_dec.op_class)
                    CLS_RTYPE: begin
                        alu_op       = w_dec.alu_op;
                        w_next_state = ST_WRITEBACK;
                    end
                    CLS_ADDI: begin
                        alu_src_b    = 1'b1;
                        w_next_state = ST_WRITEBACK;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        alu_src_b    = 1'b1;
                        w_next_state = ST_MEM;
                    end
                    CLS_BRANCH: begin
                        alu_op       = ALU_SUB;
                        pc_write     = alu_zero;
                        pc_src       = PC_SRC_BRANCH;
                        w_next_state = ST_FETCH;
                        w_retire     = 1'b1;
                    end
                    default: w_next_state = ST_FETCH;
                endcase
            end

            ST_MEM: begin
                mem_addr_sel = 1'b1;
                if (w_dec.op_class == CLS_LOAD) begin
                    mem_read = 1'b1;
                end else begin
                    mem_write = 1'b1;
                end
                if (mem_ready) begin
                    if (w_dec.op_class == CLS_LOAD) begin
                        w_next_state = ST_WRITEBACK;
                    end else begin
                        w_next_state = ST_FETCH;
                        w_retire     = 1'b1;
                    end
                end
            end

            ST_WRITEBACK: begin
                reg_write    = 1'b1;
                wb_sel       = (w_dec.op_class == CLS_LOAD);
                w_next_state = ST_FETCH;
                w_retire     = 1'b1;
            end

            ST_HALTED: w_next_state = ST_HALTED;

            default: w_next_state = ST_IDLE;
        endcase
    end

    // State register, status flags and retirement counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_armed   <= 1'b0;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
            r_count   <= '0;
        end else begin
            r_state <= w_next_state;
            r_armed <= 1'b1;
            if (w_next_state == ST_HALTED) begin
                r_halted <= 1'b1;
            end
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
            if (w_retire) begin
                r_count <= r_count + COUNT_W'(1);
            end
        end
    end

    assign halted      = r_halted;
    assign illegal     = r_illegal;
    assign instr_count = r_count;

endmodule
